// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
//
// Purpose:
//   Sequences a small up-counter datapath. A run command is taken over a
//   valid/ready handshake. The counter can optionally be cleared first. The
//   block then enables the counter until its output matches the commanded
//   target; the counter is allowed to wrap on the way. At the end it pulses
//   done and reports how many cycles the counter was enabled. That count
//   saturates at its maximum value.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rstn        asynchronous active-low reset
//   cmd_valid   a run command is present
//   cmd_ready   controller is idle and can take a command
//   cmd_target  counter value at which the run stops
//   cmd_clear   1 = clear the counter before running
//   hold        pauses counting while high (only honoured while running)
//   cnt_out     current counter output
//   cnt_en      counter enable
//   cnt_rstn    counter active-low reset (registered)
//   busy        high whenever the controller is not idle
//   done        one-cycle pulse when a run completes
//   cycles      enabled cycles of the most recent run, saturating

module counter_run_ctrl #(
  parameter int CNT_W = 4,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_target,
  input  logic             cmd_clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] cnt_out,
  output logic             cnt_en,
  output logic             cnt_rstn,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] target_q;
  logic [CYC_W-1:0] cycles_q;
  logic [CYC_W-1:0] cycles_d;
  logic             cntRstn_q;
  logic             accept;
  logic             atTarget;
  logic             cycSat;

  // Handshake, target match and counter enable.
  // The enable is combinational so the counter steps in the same cycle
  // that the controller decides to run. The target check ignores hold, so
  // a run that has already arrived ends even while paused.
  always_comb begin
    accept   = cmd_valid && (state_q == ST_IDLE);
    atTarget = (cnt_out == target_q);
    cnt_en   = (state_q == ST_RUN) && !hold && !atTarget;
    cycSat   = (cycles_q == {CYC_W{1'b1}});
  end

  // Next-state decode.
  // CLEAR and DONE are always single-cycle states. RUN stays in place until
  // the counter reaches the target, however long hold keeps it paused.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = cmd_clear ? ST_CLEAR : ST_RUN;
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (atTarget) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Enabled-cycle counter.
  // It restarts on accept. It then counts every edge where the counter
  // actually steps, and it stops at all-ones instead of wrapping. Between
  // runs it holds the last result for the stimulus layer to read.
  always_comb begin
    cycles_d = cycles_q;
    if (accept) begin
      cycles_d = '0;
    end else if (cnt_en && !cycSat) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  // State register.
  // The counter reset output is registered from the next state, so it is
  // low for exactly the CLEAR cycle. It is also low throughout a system
  // reset, and it rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      cycles_q  <= '0;
      cntRstn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      cntRstn_q <= (state_d != ST_CLEAR);
      if (accept) begin
        target_q <= cmd_target;
      end
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    cycles    = cycles_q;
    cnt_rstn  = cntRstn_q;
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl
//
// Purpose:
//   Self-checking bench for counter_run_ctrl. It holds a behavioural model
//   of the 4-bit counter, drives directed and random run commands, and uses
//   a scoreboard to check each completed run. A free-running monitor checks
//   the handshake, hold and idle behaviour on every cycle.
//
// Ports: none (top-level bench).

module tb_counter_run_ctrl;

  localparam int CNT_W   = 4;
  localparam int CYC_W   = 8;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  logic             clk;
  logic             rstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_target;
  logic             cmd_clear;
  logic             hold;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_en;
  logic             cnt_rstn;
  logic             busy;
  logic             done;
  logic [CYC_W-1:0] cycles;

  // One scoreboard entry per issued command, describing the whole run.
  typedef struct {
    int target;
    int expCycles;
    int expBusy;
    int expClr;
  } exp_t;

  exp_t sbQ[$];
  int   checks     = 0;
  int   errors     = 0;
  int   expCount   = 0;
  int   lastCycles = 0;

  counter_run_ctrl #(
    .CNT_W(CNT_W),
    .CYC_W(CYC_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_clear  (cmd_clear),
    .hold       (hold),
    .cnt_out    (cnt_out),
    .cnt_en     (cnt_en),
    .cnt_rstn   (cnt_rstn),
    .busy       (busy),
    .done       (done),
    .cycles     (cycles)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural counter: it steps on the clock while enabled and is
  // asynchronously forced to zero while its reset is low.
  always_ff @(posedge clk or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      cnt_out <= '0;
    end else if (cnt_en) begin
      cnt_out <= cnt_out + 1'b1;
    end
  end

  // One comparison. Reports a FAIL line with both values on a mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model for one command.
  // The number of steps is the wrapped distance from the starting count to
  // the target. Busy time is the optional clear cycle, the steps, any hold
  // stall, the final compare cycle in RUN, and the done cycle.
  function automatic int pushExpect(input int target, input bit clear, input int h);
    int   start;
    int   steps;
    exp_t e;
    start       = clear ? 0 : expCount;
    steps       = (target - start + CNT_MOD) % CNT_MOD;
    e.target    = target;
    e.expCycles = (steps > CYC_MAX) ? CYC_MAX : steps;
    e.expBusy   = int'(clear) + steps + ((steps > 0) ? h : 0) + 2;
    e.expClr    = int'(clear);
    sbQ.push_back(e);
    expCount    = target;
    return steps;
  endfunction

  // Waits, at negative edges, until the controller is ready. A timeout
  // counts as a failed comparison.
  task automatic waitAccept();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout actual=ready0 expected=ready1 at %0t", $time);
    end
  endtask

  // Waits, at negative edges, for a done pulse. A timeout counts as a
  // failed comparison.
  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout actual=done0 expected=done1 at %0t", $time);
    end
  endtask

  // Issues one command and runs it to completion.
  // When h is nonzero, hold is raised after k counting cycles and kept high
  // for h cycles. The count seen at the start of the pause is checked.
  task automatic applyStimulus(input int target, input bit clear, input int k, input int h);
    int start;
    int steps;
    start = clear ? 0 : expCount;
    steps = pushExpect(target, clear, h);
    @(posedge clk);
    #1;
    hold       = 1'b0;
    cmd_target = CNT_W'(target);
    cmd_clear  = clear;
    cmd_valid  = 1'b1;
    waitAccept();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (h > 0 && steps > 0) begin
      repeat (int'(clear) + k) @(posedge clk);
      #1;
      hold = 1'b1;
      @(negedge clk);
      checkOutput("countAtHold", int'(cnt_out), (start + k) % CNT_MOD);
      repeat (h) @(posedge clk);
      #1;
      hold = 1'b0;
    end
    waitDone();
  endtask

  // Two commands back to back. The second command waits on cmd_valid while
  // the first one runs.
  task automatic applyBackToBack(input int t1, input bit c1, input int t2, input bit c2);
    int s;
    s = pushExpect(t1, c1, 0);
    s = pushExpect(t2, c2, 0);
    @(posedge clk);
    #1;
    hold       = 1'b0;
    cmd_target = CNT_W'(t1);
    cmd_clear  = c1;
    cmd_valid  = 1'b1;
    waitAccept();
    @(posedge clk);
    #1;
    cmd_target = CNT_W'(t2);
    cmd_clear  = c2;
    waitAccept();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waitDone();
  endtask

  // Monitor: samples on every negative edge. It accumulates busy, enable and
  // clear cycles for the current run. When done pulses, it pops the oldest
  // scoreboard entry and compares the whole run. It also checks the idle
  // cycle that follows done.
  initial begin
    int   busyCnt;
    int   enCnt;
    int   clrCnt;
    bit   postDone;
    exp_t e;
    busyCnt  = 0;
    enCnt    = 0;
    clrCnt   = 0;
    postDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        busyCnt  = 0;
        enCnt    = 0;
        clrCnt   = 0;
        postDone = 1'b0;
      end else begin
        if (postDone) begin
          checkOutput("postDoneDone", int'(done), 0);
          checkOutput("postDoneBusy", int'(busy), 0);
          checkOutput("postDoneReady", int'(cmd_ready), 1);
          checkOutput("cyclesHeld", int'(cycles), lastCycles);
          postDone = 1'b0;
        end
        if (busy) begin
          busyCnt++;
          if (cnt_en) enCnt++;
          if (!cnt_rstn) clrCnt++;
          checkOutput("readyWhileBusy", int'(cmd_ready), 0);
          if (hold) checkOutput("enDuringHold", int'(cnt_en), 0);
        end else begin
          checkOutput("enWhileIdle", int'(cnt_en), 0);
        end
        if (done) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone actual=done1 expected=done0 at %0t", $time);
          end else begin
            e = sbQ.pop_front();
            checkOutput("finalCount", int'(cnt_out), e.target);
            checkOutput("cyclesResult", int'(cycles), e.expCycles);
            checkOutput("enabledCycles", enCnt, e.expCycles);
            checkOutput("busyCycles", busyCnt, e.expBusy);
            checkOutput("clearCycles", clrCnt, e.expClr);
            lastCycles = e.expCycles;
            postDone   = 1'b1;
          end
        end
        if (cmd_valid && cmd_ready) begin
          busyCnt = 0;
          enCnt   = 0;
          clrCnt  = 0;
        end
      end
    end
  end

  // Watchdog in case something stalls outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  // Covers reset values, clear-and-run, wrap-around, target equal to the
  // current count, hold, back-to-back commands, reset in the middle of a
  // run, and then a batch of random commands.
  initial begin
    int target;
    int start;
    int steps;
    int k;
    int h;
    bit clear;

    rstn       = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_clear  = 1'b0;
    hold       = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstEn", int'(cnt_en), 0);
    checkOutput("rstCntRstn", int'(cnt_rstn), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstCycles", int'(cycles), 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("relReady", int'(cmd_ready), 1);
    checkOutput("relCntRstnLow", int'(cnt_rstn), 0);
    @(negedge clk);
    checkOutput("relCntRstnHigh", int'(cnt_rstn), 1);

    $display("[TB] directed runs");
    applyStimulus(5, 1'b1, 0, 0);
    applyStimulus(14, 1'b0, 0, 0);
    applyStimulus(2, 1'b0, 0, 0);
    applyStimulus(7, 1'b0, 0, 0);
    applyStimulus(7, 1'b0, 0, 0);
    applyStimulus(6, 1'b1, 2, 3);
    applyBackToBack(10, 1'b0, 3, 1'b1);

    $display("[TB] reset during run");
    target = pushExpect(9, 1'b1, 0);
    @(posedge clk);
    #1;
    cmd_target = CNT_W'(9);
    cmd_clear  = 1'b1;
    cmd_valid  = 1'b1;
    waitAccept();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cnt_out != CNT_W'(3) && k < 50);
    checkOutput("midRunCount", int'(cnt_out), 3);
    rstn = 1'b0;
    sbQ.delete();
    expCount = 0;
    #1;
    checkOutput("midRstEn", int'(cnt_en), 0);
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstCntRstn", int'(cnt_rstn), 0);
    checkOutput("midRstCycles", int'(cycles), 0);
    checkOutput("midRstDone", int'(done), 0);
    checkOutput("midRstCount", int'(cnt_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(4, 1'b0, 0, 0);

    $display("[TB] random runs");
    for (int i = 0; i < 24; i++) begin
      target = int'($urandom_range(0, CNT_MOD - 1));
      clear  = 1'($urandom_range(0, 1));
      start  = clear ? 0 : expCount;
      steps  = (target - start + CNT_MOD) % CNT_MOD;
      h      = int'($urandom_range(0, 3));
      k      = (steps > 0) ? int'($urandom_range(0, steps - 1)) : 0;
      @(posedge clk);
      #1;
      hold = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(target, clear, k, h);
    end

    repeat (3) @(posedge clk);
    checkOutput("queueEmpty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
